apb_master_ctrl: RTL and testbench

Single-outstanding APB requester for the I2C subsystem's host side. It accepts one command at a time on a valid/ready port and drives the full APB SETUP/ACCESS sequence toward a slave such as the APB-to-I2C bridge. It then returns read data, slave error or timeout status on a valid/ready response port. Typical use: a bench or embedded sequencer programs the I2C bridge's TX FIFO (0x0), RX FIFO (0x4), timeout (0x8) and config (0xC) registers.

---
 rtl/apb_master_ctrl.sv | 133 +++++++++++++
 tb/tb_apb_master_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB requester: takes one command on a valid/ready port,
// runs the APB SETUP/ACCESS sequence and returns the result on a valid/ready response port.
module apb_master_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_pclk,
    input  logic        i_presetn,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_error,
    output logic        o_rsp_timeout,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [31:0] o_paddr,
    output logic [31:0] o_pwdata,
    input  logic [31:0] i_prdata,
    input  logic        i_pready,
    input  logic        i_pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_error;
    logic        r_rsp_timeout;

    // Transfer sequencer: state, APB drive and response registers
    always_ff @(posedge i_pclk) begin
        if (!i_presetn) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= 8'd0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= 32'd0;
            r_pwdata      <= 32'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_pwrite  <= i_cmd_write;
                        r_paddr   <= i_cmd_addr;
                        r_pwdata  <= i_cmd_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= ST_SETUP;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= 8'd0;
                    r_state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A ready slave beats a timeout that would fire on the same edge
                    if (i_pready) begin
                        r_rsp_rdata   <= r_pwrite ? 32'd0 : i_prdata;
                        r_rsp_error   <= i_pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_RESP;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_rsp_rdata   <= 32'd0;
                        r_rsp_error   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_RESP;
                    end else begin
                        r_wait_cnt    <= r_wait_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (r_rsp_valid && i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_RESP;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_ready   = (r_state == ST_IDLE);
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_error   = r_rsp_error;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_psel        = r_psel;
    assign o_penable     = r_penable;
    assign o_pwrite      = r_pwrite;
    assign o_paddr       = r_paddr;
    assign o_pwdata      = r_pwdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: table of transfers driven against a
// bench-side APB slave, responses checked through a scoreboard queue.
module tb_apb_master_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error, rsp_timeout;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr_wait;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_acc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t sb[$];
    vec_t tbl[8];

    apb_master_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .i_pclk(clk), .i_presetn(presetn),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error), .o_rsp_timeout(rsp_timeout),
        .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite),
        .o_paddr(paddr), .o_pwdata(pwdata),
        .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_reset();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_pwrite", 32'(pwrite), 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    endtask

    // Accept a command, check SETUP, and step into the first ACCESS cycle
    task automatic issue(input vec_t v);
        rsp_t e;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.to    = v.exp_to;
        sb.push_back(e);
        tick();
        cmd_valid = 1'b0;
        check("setup_psel", 32'(psel), 32'd1);
        check("setup_penable", 32'(penable), 32'd0);
        check("setup_paddr", paddr, v.addr);
        check("setup_pwdata", pwdata, v.wdata);
        check("setup_pwrite", 32'(pwrite), 32'(v.wr));
        check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
    endtask

    // Bench-side slave: wait states, then PREADY with read data / error
    task automatic access_phase(input vec_t v);
        int  acc = 0;
        bit  done = 1'b0;
        logic rdy;
        while (!done && acc < 50) begin
            check("acc_psel", 32'(psel), 32'd1);
            check("acc_penable", 32'(penable), 32'd1);
            check("acc_paddr", paddr, v.addr);
            check("acc_pwdata", pwdata, v.wdata);
            check("acc_rsp_valid", 32'(rsp_valid), 32'd0);
            rdy     = (acc == v.waits);
            pready  = rdy;
            prdata  = rdy ? v.prdata : 32'hDEAD_BEEF;
            pslverr = rdy ? v.slverr : v.slverr_wait;
            tick();
            acc++;
            if (rsp_valid) done = 1'b1;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL access_bound: got no response after %0d cycles", acc);
        end
        check("acc_cycles", 32'(acc), 32'(v.exp_acc));
        check("end_psel", 32'(psel), 32'd0);
        check("end_penable", 32'(penable), 32'd0);
        check("end_paddr_held", paddr, v.addr);
    endtask

    task automatic take_resp();
        rsp_t e;
        check("rsp_valid_before", 32'(rsp_valid), 32'd1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty: got response with no expected entry, expected an entry");
        end else begin
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_error", 32'(rsp_error), 32'(e.err));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        rsp_t held;
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
        prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

        //         wr    addr      wdata          waits prdata          slv_w slv   exp_rdata       err   to    acc
        tbl[0] = '{1'b1, 32'h8,    32'h0000_1234, 0,    32'hCAFE_F00D,  1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1};
        tbl[1] = '{1'b0, 32'h4,    32'h1111_1111, 3,    32'hA5A5_5A5A,  1'b0, 1'b0, 32'hA5A5_5A5A,  1'b0, 1'b0, 4};
        tbl[2] = '{1'b1, 32'h0,    32'h0000_0055, 2,    32'h0,          1'b1, 1'b1, 32'h0,          1'b1, 1'b0, 3};
        tbl[3] = '{1'b0, 32'h8,    32'h0,         2,    32'h0000_0010,  1'b1, 1'b0, 32'h0000_0010,  1'b0, 1'b0, 3};
        tbl[4] = '{1'b0, 32'hC,    32'h0,         99,   32'h7777_7777,  1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 4};
        tbl[5] = '{1'b0, 32'hC,    32'h0,         3,    32'h1357_9BDF,  1'b0, 1'b0, 32'h1357_9BDF,  1'b0, 1'b0, 4};
        tbl[6] = '{1'b1, 32'h4,    32'hABCD_0000, 99,   32'h0,          1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 4};
        tbl[7] = '{1'b0, 32'h0,    32'h0,         1,    32'hFFFF_FFFF,  1'b0, 1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 2};

        tick(); tick();
        presetn = 1'b1;
        check_idle_reset();

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i]);
            access_phase(tbl[i]);
            take_resp();
        end

        // Response back-pressure with a command queued behind it
        v = tbl[1];
        v.waits = 0; v.exp_acc = 1;
        issue(v);
        access_phase(v);
        held.rdata = rsp_rdata; held.err = rsp_error; held.to = rsp_timeout;
        cmd_valid = 1'b1; cmd_write = tbl[0].wr; cmd_addr = tbl[0].addr; cmd_wdata = tbl[0].wdata;
        for (int k = 0; k < 5; k++) begin
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, held.rdata);
            check("bp_psel", 32'(psel), 32'd0);
            tick();
        end
        take_resp();
        check("bp_psel_after_hs", 32'(psel), 32'd0);
        issue(tbl[0]);
        access_phase(tbl[0]);
        take_resp();

        // Reset in the middle of ACCESS drops the transfer
        issue(tbl[4]);
        tick();
        presetn = 1'b0;
        tick();
        presetn = 1'b1;
        sb.delete();
        check_idle_reset();
        for (int k = 0; k < 6; k++) begin
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        issue(tbl[3]);
        access_phase(tbl[3]);
        take_resp();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
